// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall vectors,
// FSM state codes and the redirect payload driven to pc_reg.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned ADDR_W  = 32;

  // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold
  localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_FROM_ID = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_FROM_EX = 6'b001111;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_MULTI = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges ID/EX stall requests, sequences multi-cycle EX
// ops, issues timed flush/redirect on exceptions and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_CNT_W     = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                excp_valid,
  input  logic [ADDR_W-1:0]   excp_pc,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   new_pc,
  output logic                mc_done,
  output logic                busy,
  output logic [PERF_W-1:0]   stall_cnt
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e         state, state_nxt;
  logic [MC_CNT_W-1:0] cnt, cnt_nxt;
  logic [FCNT_W-1:0]   fcnt, fcnt_nxt;
  redirect_t           redir, redir_nxt;
  logic [MC_CNT_W-1:0] mc_load;

  // A zero-length op behaves as a single-cycle op.
  assign mc_load = (mc_cycles == '0) ? '0 : (mc_cycles - MC_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CTRL_RUN;
      cnt   <= '0;
      fcnt  <= '0;
      redir <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fcnt  <= fcnt_nxt;
      redir <= redir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt;
    redir_nxt = redir;
    stall     = STALL_NONE;
    mc_done   = 1'b0;

    // An exception from any state (re)starts the flush window; stall stays clear.
    if (excp_valid) begin
      state_nxt       = CTRL_FLUSH;
      fcnt_nxt        = FCNT_LOAD;
      redir_nxt.valid = 1'b1;
      redir_nxt.pc    = excp_pc;
    end else begin
      case (state)
        CTRL_RUN: begin
          if (mc_start) begin
            stall     = STALL_FROM_EX;
            state_nxt = CTRL_MULTI;
            cnt_nxt   = mc_load;
          end else if (stallreq_ex) begin
            stall = STALL_FROM_EX;
          end else if (stallreq_id) begin
            stall = STALL_FROM_ID;
          end
        end
        CTRL_MULTI: begin
          // ID/EX hold requests are irrelevant while EX is frozen.
          if (cnt != '0) begin
            stall   = STALL_FROM_EX;
            cnt_nxt = cnt - MC_CNT_W'(1);
          end else begin
            mc_done   = 1'b1;
            state_nxt = CTRL_RUN;
          end
        end
        CTRL_FLUSH: begin
          if (fcnt != '0) begin
            fcnt_nxt = fcnt - FCNT_W'(1);
          end else begin
            redir_nxt.valid = 1'b0;
            state_nxt       = CTRL_RUN;
          end
        end
        default: begin
          state_nxt       = CTRL_RUN;
          redir_nxt.valid = 1'b0;
        end
      endcase
    end

    if (rst) begin
      stall   = STALL_NONE;
      mc_done = 1'b0;
    end
  end

  assign flush  = redir.valid;
  assign new_pc = redir.pc;
  assign busy   = (state != CTRL_RUN);

  sat_counter #(
    .W(PERF_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stall[0]),
    .count(stall_cnt)
  );

endmodule
